step_pulse_gen: RTL and testbench
=================================

// Module: step_pulse_gen
// PURPOSE
//  Parametrised step/direction pulse generator for the RF2/RF3 motor drive path.
//  It emits a counted burst or a continuous train of STEP pulses. Period, high time,
//  pulse count, direction and polarity are programmed per command.
//  Provides start/stop/busy/done handshake and a direction-setup delay.
//  Sits between the motion controller registers and the driver IC pins.
// PARAMETERS
//  WIDTH      16  width of period / high-time fields and timers (cycles)
//  CNT_W      16  width of pulse-count field and pulses_done counter
//  DIR_SETUP  4   clk cycles drv_dir is stable before first STEP edge (>=1)
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  cfg_period   in   WIDTH  step period in cycles; values <2 treated as 2
//  cfg_high     in   WIDTH  step high time; clamped to [1, period-1]
//  cfg_count    in   CNT_W  pulses per burst (mode 0)
//  cfg_mode     in   1      0 = counted burst, 1 = continuous until stop
//  cfg_dir      in   1      direction level for this command
//  cfg_invert   in   1      1 = active-low STEP output
//  start        in   1      1-cycle command strobe; cfg_* sampled on it
//  stop         in   1      graceful stop request
//  busy         out  1      command in progress
//  done         out  1      1-cycle pulse at command completion
//  pulses_done  out  CNT_W  pulses emitted in current/last command
//  drv_pulse    out  1      STEP pin (registered)
//  drv_dir      out  1      DIR pin (registered)
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, pulses_done=0, drv_pulse=0, drv_dir=0,
//   latched invert=0. rst mid-command aborts immediately, no done pulse.
//  All outputs registered. cfg_* latched only on accepted start.
//  FSM IDLE -> SETUP -> RUN -> IDLE:
//   IDLE: drv_pulse = latched invert (inactive level). start at cycle t:
//    latch cfg, clamp period/high, pulses_done<=0, drv_dir<=cfg_dir, busy<=1 at t+1.
//    If mode 0 and cfg_count==0: skip SETUP/RUN; done=1 at t+1, busy=0 at t+2.
//   SETUP: DIR_SETUP cycles; first STEP active edge at cycle t+1+DIR_SETUP.
//   RUN: timer 0..P-1; STEP active for timer<H, inactive otherwise.
//    pulses_done increments on each active edge.
//    Mode 0: after the Nth pulse's full period -> IDLE; done=1 for one cycle, busy=0.
//    Mode 1: pulses_done wraps modulo 2^CNT_W.
//  stop: honoured in SETUP/RUN. The current period completes (no truncated pulse),
//   then IDLE with done. stop in SETUP ends with 0 pulses. stop in IDLE ignored.
//  start while busy ignored (cfg unchanged). start+stop same cycle in IDLE: start
//   accepted, stop ignored. stop on final period of a burst: single done.
//  done asserted same cycle busy falls; back-to-back start accepted on that cycle's
//   successor (IDLE).
//  drv_pulse = step ^ inv_latched; never glitches (single flop output).
// STRUCTURE
//  Package pulse_pkg: state enum {IDLE,SETUP,RUN}, mode constants MODE_COUNT/MODE_CONT,
//   MIN_PERIOD=2.
//  Sub-module pulse_period_timer (WIDTH): free-running 0..P-1 counter with
//   period_end/high flags. FSM, clamping and count logic in the top.
// TESTING
//  1 mode0 P=10 H=3 N=4 dir=1 inv=0 -> 4 pulses, 3 high/7 low;
//    first rise at start+1+DIR_SETUP; done one cycle after 40-cycle RUN; pulses_done=4.
//  2 inv=1, same cfg -> drv_pulse idle 1, active-low; timing identical to 1.
//  3 clamps: P=0 H=0 N=2 -> period 2, high 1. P=5 H=9 -> high 4.
//  4 mode1 P=8 H=2; stop mid-high of 6th pulse -> 6th completes full 8 cycles;
//    done once; pulses_done=6.
//  5 N=0 -> done at t+1, drv_pulse never active. Start during busy -> ignored,
//    count unchanged. Stop in IDLE -> no effect.
//  6 rst asserted in RUN -> next cycle all outputs at reset values, no done;
//    new start afterwards runs normally.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and constants for the step/direction pulse generator.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_CONT  = 1'b1;

  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_period_timer.sv
// Free-running 0..period-1 counter with phase flags for one STEP period.
module pulse_period_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] high,
  output logic             period_start,
  output logic             period_end,
  output logic             high_phase
);

  logic [WIDTH-1:0] count;

  // Count up and wrap at period-1; held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == period - WIDTH'(1)) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  // Decode phase flags from the current count.
  always_comb begin
    period_start = (count == '0);
    period_end   = (count == period - WIDTH'(1));
    high_phase   = (count < high);
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator: counted bursts or continuous STEP trains
// with a direction-setup delay and start/stop/busy/done handshake.
module step_pulse_gen
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DIR_SETUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_mode,
  input  logic             cfg_dir,
  input  logic             cfg_invert,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_done,
  output logic             drv_pulse,
  output logic             drv_dir
);

  localparam int unsigned SW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP + 1) : 1;

  state_t           state;
  logic [SW-1:0]    setup_cnt;
  logic [WIDTH-1:0] period_l;
  logic [WIDTH-1:0] high_l;
  logic [CNT_W-1:0] count_l;
  logic             mode_l;
  logic             inv_l;
  logic             stop_pend;
  logic             fin;

  logic [WIDTH-1:0] period_c;
  logic [WIDTH-1:0] high_c;
  logic             accept;
  logic             step;
  logic             tmr_clear;
  logic             tmr_start;
  logic             tmr_end;
  logic             tmr_high;

  // Clamp the requested period and high time to a legal waveform.
  always_comb begin
    period_c = (cfg_period < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : cfg_period;
    high_c   = cfg_high;
    if (cfg_high == '0) begin
      high_c = WIDTH'(1);
    end else if (cfg_high >= period_c) begin
      high_c = period_c - WIDTH'(1);
    end
  end

  // Command acceptance and the unregistered STEP level of the running period.
  always_comb begin
    accept    = start && (state == IDLE) && !busy;
    tmr_clear = (state != RUN);
    step      = (state == RUN) && tmr_high;
  end

  pulse_period_timer #(
    .WIDTH(WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (tmr_clear),
    .period      (period_l),
    .high        (high_l),
    .period_start(tmr_start),
    .period_end  (tmr_end),
    .high_phase  (tmr_high)
  );

  // Control FSM. The internal state runs one cycle ahead of the registered
  // pins: SETUP lasts DIR_SETUP-1 cycles and busy/done are released one cycle
  // after RUN ends (via fin), so every pin stays a plain flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      setup_cnt   <= '0;
      period_l    <= WIDTH'(MIN_PERIOD);
      high_l      <= WIDTH'(1);
      count_l     <= '0;
      mode_l      <= MODE_COUNT;
      inv_l       <= 1'b0;
      stop_pend   <= 1'b0;
      fin         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_done <= '0;
      drv_pulse   <= 1'b0;
      drv_dir     <= 1'b0;
    end else begin
      done      <= 1'b0;
      drv_pulse <= step ^ inv_l;
      case (state)
        IDLE: begin
          fin <= 1'b0;
          if (accept) begin
            period_l    <= period_c;
            high_l      <= high_c;
            count_l     <= cfg_count;
            mode_l      <= cfg_mode;
            inv_l       <= cfg_invert;
            drv_pulse   <= cfg_invert;
            drv_dir     <= cfg_dir;
            pulses_done <= '0;
            stop_pend   <= 1'b0;
            busy        <= 1'b1;
            if (cfg_mode == MODE_COUNT && cfg_count == '0) begin
              done <= 1'b1;
            end else if (DIR_SETUP <= 1) begin
              state <= RUN;
            end else begin
              state     <= SETUP;
              setup_cnt <= SW'(DIR_SETUP - 1);
            end
          end else begin
            busy <= 1'b0;
            done <= fin;
          end
        end
        SETUP: begin
          if (stop || stop_pend) begin
            state <= IDLE;
            fin   <= 1'b1;
          end else if (setup_cnt == SW'(1)) begin
            state <= RUN;
          end else begin
            setup_cnt <= setup_cnt - SW'(1);
          end
        end
        RUN: begin
          if (tmr_start) begin
            pulses_done <= pulses_done + CNT_W'(1);
          end
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (tmr_end) begin
            if ((mode_l == MODE_COUNT && pulses_done == count_l) || stop || stop_pend) begin
              state <= IDLE;
              fin   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed self-checking bench for step_pulse_gen.
module tb_step_pulse_gen;

  localparam int W  = 16;
  localparam int C  = 16;
  localparam int DS = 4;
  localparam int R  = DS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_high;
  logic [C-1:0] cfg_count;
  logic         cfg_mode;
  logic         cfg_dir;
  logic         cfg_invert;
  logic         start;
  logic         stop;
  logic         busy;
  logic         done;
  logic [C-1:0] pulses_done;
  logic         drv_pulse;
  logic         drv_dir;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .WIDTH    (W),
    .CNT_W    (C),
    .DIR_SETUP(DS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_count  (cfg_count),
    .cfg_mode   (cfg_mode),
    .cfg_dir    (cfg_dir),
    .cfg_invert (cfg_invert),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .pulses_done(pulses_done),
    .drv_pulse  (drv_pulse),
    .drv_dir    (drv_dir)
  );

  // Expected waveform of a command ending after n pulses; k counts cycles after the start cycle.
  function automatic logic m_pulse(int k, int p, int h, int n, int inv);
    logic a;
    a = (k >= R) && (k < R + p * n) && (((k - R) % p) < h);
    return a ^ (inv != 0);
  endfunction

  function automatic logic m_busy(int k, int p, int n);
    return (k >= 1) && (k < R + p * n);
  endfunction

  function automatic logic m_done(int k, int p, int n);
    return k == R + p * n;
  endfunction

  function automatic int m_cnt(int k, int p, int n);
    int c;
    if (k < R) return 0;
    c = (k - R) / p + 1;
    return (c > n) ? n : c;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, pulses_done, drv_pulse, drv_dir} !== '0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b cnt=%0d pulse=%b dir=%b required all 0",
               busy, done, pulses_done, drv_pulse, drv_dir);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, pulses_done, drv_pulse, drv_dir} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_idle busy=%b done=%b cnt=%0d pulse=%b dir=%b required all 0",
               busy, done, pulses_done, drv_pulse, drv_dir);
    end
  endtask

  // Counted burst; p/h are the clamped values the waveform must show.
  task automatic test_burst(input string name, input int p_cfg, input int h_cfg, input int n,
                            input int inv, input int dir, input int p, input int h);
    cfg_period = W'(p_cfg);
    cfg_high   = W'(h_cfg);
    cfg_count  = C'(n);
    cfg_mode   = 1'b0;
    cfg_dir    = dir[0];
    cfg_invert = inv[0];
    start      = 1'b1;
    for (int k = 1; k <= R + p * n + 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (drv_pulse !== m_pulse(k, p, h, n, inv)) begin
        n_fail++;
        $display("FAIL %s drv_pulse k=%0d got %b required %b", name, k, drv_pulse, m_pulse(k, p, h, n, inv));
      end
      n_checks++;
      if (busy !== m_busy(k, p, n)) begin
        n_fail++;
        $display("FAIL %s busy k=%0d got %b required %b", name, k, busy, m_busy(k, p, n));
      end
      n_checks++;
      if (done !== m_done(k, p, n)) begin
        n_fail++;
        $display("FAIL %s done k=%0d got %b required %b", name, k, done, m_done(k, p, n));
      end
      n_checks++;
      if (pulses_done !== C'(m_cnt(k, p, n))) begin
        n_fail++;
        $display("FAIL %s pulses_done k=%0d got %0d required %0d", name, k, pulses_done, m_cnt(k, p, n));
      end
      n_checks++;
      if (drv_dir !== dir[0]) begin
        n_fail++;
        $display("FAIL %s drv_dir k=%0d got %b required %b", name, k, drv_dir, dir[0]);
      end
    end
  endtask

  // Continuous train stopped during the high phase of pulse 6 (P=8, H=2).
  task automatic test_cont_stop();
    int n_done;
    n_done     = 0;
    cfg_period = W'(8);
    cfg_high   = W'(2);
    cfg_count  = C'(0);
    cfg_mode   = 1'b1;
    cfg_dir    = 1'b0;
    cfg_invert = 1'b0;
    start      = 1'b1;
    for (int k = 1; k <= R + 48 + 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      if (done === 1'b1) n_done++;
      n_checks++;
      if (drv_pulse !== m_pulse(k, 8, 2, 6, 0)) begin
        n_fail++;
        $display("FAIL cont_stop drv_pulse k=%0d got %b required %b", k, drv_pulse, m_pulse(k, 8, 2, 6, 0));
      end
      n_checks++;
      if (busy !== m_busy(k, 8, 6) || done !== m_done(k, 8, 6)) begin
        n_fail++;
        $display("FAIL cont_stop busy/done k=%0d got %b/%b required %b/%b", k, busy, done,
                 m_busy(k, 8, 6), m_done(k, 8, 6));
      end
      if (k == R + 40) stop = 1'b1;
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL cont_stop done_count got %0d required 1", n_done);
    end
    n_checks++;
    if (pulses_done !== C'(6)) begin
      n_fail++;
      $display("FAIL cont_stop pulses_done got %0d required 6", pulses_done);
    end
  endtask

  // Zero-count burst, stop in IDLE, and stop during the direction setup.
  task automatic test_zero_and_idle_stop();
    cfg_period = W'(10);
    cfg_high   = W'(3);
    cfg_count  = C'(0);
    cfg_mode   = 1'b0;
    cfg_dir    = 1'b1;
    cfg_invert = 1'b0;
    start      = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (done !== (k == 1) || busy !== (k == 1) || drv_pulse !== 1'b0 || pulses_done !== '0) begin
        n_fail++;
        $display("FAIL zero_count k=%0d done=%b busy=%b pulse=%b cnt=%0d required done=busy=%b pulse=0 cnt=0",
                 k, done, busy, drv_pulse, pulses_done, (k == 1));
      end
    end
    stop = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      stop = 1'b0;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || drv_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_stop k=%0d done=%b busy=%b pulse=%b required 0", k, done, busy, drv_pulse);
      end
    end
    cfg_count = C'(3);
    start     = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = (k == 2);
      n_checks++;
      if (done !== (k == 4) || busy !== (k < 4) || drv_pulse !== 1'b0 || pulses_done !== '0) begin
        n_fail++;
        $display("FAIL setup_stop k=%0d done=%b busy=%b pulse=%b cnt=%0d required done=%b busy=%b pulse=0 cnt=0",
                 k, done, busy, drv_pulse, pulses_done, (k == 4), (k < 4));
      end
    end
    stop = 1'b0;
  endtask

  // start+stop together in IDLE is a normal start; a later start while busy is ignored.
  task automatic test_start_while_busy();
    cfg_period = W'(10);
    cfg_high   = W'(3);
    cfg_count  = C'(4);
    cfg_mode   = 1'b0;
    cfg_dir    = 1'b1;
    cfg_invert = 1'b0;
    start      = 1'b1;
    stop       = 1'b1;
    for (int k = 1; k <= R + 43; k++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      n_checks++;
      if (drv_pulse !== m_pulse(k, 10, 3, 4, 0) || busy !== m_busy(k, 10, 4) ||
          done !== m_done(k, 10, 4) || pulses_done !== C'(m_cnt(k, 10, 4)) || drv_dir !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_start k=%0d pulse=%b busy=%b done=%b cnt=%0d dir=%b required %b %b %b %0d 1",
                 k, drv_pulse, busy, done, pulses_done, drv_dir, m_pulse(k, 10, 3, 4, 0),
                 m_busy(k, 10, 4), m_done(k, 10, 4), m_cnt(k, 10, 4));
      end
      if (k == 10) begin
        cfg_period = W'(4);
        cfg_count  = C'(1);
        cfg_dir    = 1'b0;
        cfg_invert = 1'b1;
        start      = 1'b1;
      end
    end
  endtask

  // Reset in RUN aborts with no done; the next command runs normally.
  task automatic test_rst_mid_run();
    int n_done;
    n_done     = 0;
    cfg_period = W'(10);
    cfg_high   = W'(3);
    cfg_count  = C'(4);
    cfg_mode   = 1'b0;
    cfg_dir    = 1'b1;
    cfg_invert = 1'b1;
    start      = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, pulses_done, drv_pulse, drv_dir} !== '0) begin
      n_fail++;
      $display("FAIL rst_abort busy=%b done=%b cnt=%0d pulse=%b dir=%b required all 0",
               busy, done, pulses_done, drv_pulse, drv_dir);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || drv_pulse === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL rst_quiet active_cycles got %0d required 0", n_done);
    end
    test_burst("after_rst", 6, 2, 2, 0, 0, 6, 2);
  endtask

  // A new start in the done cycle is accepted.
  task automatic test_back_to_back();
    cfg_period = W'(4);
    cfg_high   = W'(2);
    cfg_count  = C'(1);
    cfg_mode   = 1'b0;
    cfg_dir    = 1'b1;
    cfg_invert = 1'b0;
    start      = 1'b1;
    for (int k = 1; k <= R + 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (done !== m_done(k, 4, 1) || busy !== m_busy(k, 4, 1)) begin
        n_fail++;
        $display("FAIL b2b_first k=%0d done=%b busy=%b required %b %b", k, done, busy,
                 m_done(k, 4, 1), m_busy(k, 4, 1));
      end
    end
    test_burst("b2b_second", 4, 2, 2, 0, 0, 4, 2);
  endtask

  initial begin
    cfg_period = '0;
    cfg_high   = '0;
    cfg_count  = '0;
    cfg_mode   = 1'b0;
    cfg_dir    = 1'b0;
    cfg_invert = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    @(negedge clk);
    test_reset();
    test_burst("burst_p10_h3", 10, 3, 4, 0, 1, 10, 3);
    repeat (2) @(negedge clk);
    test_burst("burst_inv", 10, 3, 4, 1, 1, 10, 3);
    repeat (2) @(negedge clk);
    test_burst("clamp_p0_h0", 0, 0, 2, 0, 0, 2, 1);
    repeat (2) @(negedge clk);
    test_burst("clamp_h9_p5", 5, 9, 2, 0, 1, 5, 4);
    repeat (2) @(negedge clk);
    test_cont_stop();
    repeat (2) @(negedge clk);
    test_zero_and_idle_stop();
    repeat (2) @(negedge clk);
    test_start_while_busy();
    repeat (2) @(negedge clk);
    test_rst_mid_run();
    repeat (2) @(negedge clk);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
